// File: rtl/voice_path_if.sv
// Bundles the voice request/control inputs and the sample/status outputs.
// The master side (sequencer or bench) issues requests; the voice path is the slave.
interface voice_path_if #(
    parameter int SAMPLE_W = 8,
    parameter int DIV_W    = 19,
    parameter int VOL_W    = 4
);
    logic                sample_now;
    logic [DIV_W-1:0]    divisor;
    logic [2:0]          mode;
    logic [SAMPLE_W-1:0] duty;
    logic [VOL_W-1:0]    volume;
    logic [SAMPLE_W-1:0] sample;
    logic                done;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_now, divisor, mode, duty, volume,
        input  sample, done, busy, overrun
    );

    modport slave (
        input  sample_now, divisor, mode, duty, volume,
        output sample, done, busy, overrun
    );
endinterface

// File: rtl/voice_path.sv
// Single-voice sound path: free-running phase counter, sequential restoring
// divider that normalises count/divisor to a SAMPLE_W-bit phase, waveshaper
// and volume scaler. One conversion per sample_now request.
module voice_path #(
    parameter int SAMPLE_W = 8,
    parameter int DIV_W    = 19,
    parameter int VOL_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    voice_path_if.slave vp
);

    localparam int CTR_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam logic [CTR_W-1:0]    LAST_BIT = CTR_W'(SAMPLE_W - 1);
    localparam logic [CTR_W-1:0]    CTR_ONE  = CTR_W'(1);
    localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
    localparam logic [VOL_W:0]      VOL_ONE  = (VOL_W + 1)'(1);
    localparam logic [SAMPLE_W-1:0] MAX_VAL  = '1;

    localparam logic [2:0] MODE_SQUARE   = 3'd1;
    localparam logic [2:0] MODE_SAW      = 3'd2;
    localparam logic [2:0] MODE_TRIANGLE = 3'd3;
    localparam logic [2:0] MODE_PULSE    = 3'd4;
    localparam logic [2:0] MODE_REV_SAW  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        SHAPE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [DIV_W-1:0]    cnt_reg;
    logic [DIV_W-1:0]    prev_div_reg;

    logic [DIV_W:0]      rem_reg;
    logic [SAMPLE_W-1:0] q_reg;
    logic [CTR_W-1:0]    bit_ctr_reg;
    logic [DIV_W-1:0]    div_lat_reg;
    logic [2:0]          mode_lat_reg;
    logic [SAMPLE_W-1:0] duty_lat_reg;
    logic [VOL_W-1:0]    vol_lat_reg;

    logic [SAMPLE_W-1:0] sample_reg;
    logic                done_reg;
    logic                overrun_reg;

    logic load, step, finish, drop;

    logic [DIV_W:0]      rem_shift;
    logic [DIV_W:0]      div_ext;
    logic                sub_ok;
    logic [DIV_W:0]      rem_diff;

    logic                div_zero;
    logic [SAMPLE_W-1:0] q_eff;
    logic                q_msb;
    logic [SAMPLE_W-1:0] tri_wave;
    logic [SAMPLE_W-1:0] shaped;
    logic [VOL_W:0]      vol_plus;
    logic [SAMPLE_W+VOL_W:0] product;
    logic [SAMPLE_W-1:0] scaled;

    // Phase counter: wraps at divisor-1, restarts whenever the divisor changes, idles at 0 when silent
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            prev_div_reg <= '0;
        end else begin
            prev_div_reg <= vp.divisor;
            if (vp.divisor == '0 || vp.divisor != prev_div_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == vp.divisor - DIV_ONE) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + DIV_ONE;
            end
        end
    end

    // Conversion FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one DIV step per quotient bit, then a single SHAPE cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (vp.sample_now) state_next = DIV;
            DIV:     if (bit_ctr_reg == LAST_BIT) state_next = SHAPE;
            SHAPE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: datapath strobes; a request seen while not idle is dropped
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        drop   = 1'b0;
        case (state_reg)
            IDLE:    load   = vp.sample_now;
            DIV:     begin step = 1'b1;   drop = vp.sample_now; end
            SHAPE:   begin finish = 1'b1; drop = vp.sample_now; end
            default: drop   = vp.sample_now;
        endcase
    end

    // Restoring divider step: shift remainder, subtract divisor when it fits
    always_comb begin
        rem_shift = rem_reg << 1;
        div_ext   = {1'b0, div_lat_reg};
        sub_ok    = (rem_shift >= div_ext);
        rem_diff  = rem_shift - div_ext;
    end

    // Divider datapath and request latch; inputs are frozen at the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg      <= '0;
            q_reg        <= '0;
            bit_ctr_reg  <= '0;
            div_lat_reg  <= '0;
            mode_lat_reg <= '0;
            duty_lat_reg <= '0;
            vol_lat_reg  <= '0;
        end else if (load) begin
            rem_reg      <= {1'b0, cnt_reg};
            q_reg        <= '0;
            bit_ctr_reg  <= '0;
            div_lat_reg  <= vp.divisor;
            mode_lat_reg <= vp.mode;
            duty_lat_reg <= vp.duty;
            vol_lat_reg  <= vp.volume;
        end else if (step) begin
            rem_reg     <= sub_ok ? rem_diff : rem_shift;
            q_reg       <= {q_reg[SAMPLE_W-2:0], sub_ok};
            bit_ctr_reg <= bit_ctr_reg + CTR_ONE;
        end
    end

    assign div_zero = (div_lat_reg == '0);
    assign q_eff    = div_zero ? '0 : q_reg;
    assign q_msb    = q_eff[SAMPLE_W-1];

    // Triangle fold: phase doubled, mirrored in the upper half of the period
    generate
        for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_tri
            if (gi == 0) begin : g_lsb
                assign tri_wave[gi] = q_msb;
            end else begin : g_upper
                assign tri_wave[gi] = q_eff[gi-1] ^ q_msb;
            end
        end
    endgenerate

    // Waveshaper: a silent divisor overrides every mode
    always_comb begin
        shaped = '0;
        if (!div_zero) begin
            case (mode_lat_reg)
                MODE_SQUARE:   shaped = q_msb ? '0 : MAX_VAL;
                MODE_SAW:      shaped = q_eff;
                MODE_TRIANGLE: shaped = tri_wave;
                MODE_PULSE:    shaped = (q_eff < duty_lat_reg) ? MAX_VAL : '0;
                MODE_REV_SAW:  shaped = ~q_eff;
                default:       shaped = '0;
            endcase
        end
    end

    // Volume scaling: full-width product, keep the bits above the volume fraction
    always_comb begin
        vol_plus = {1'b0, vol_lat_reg} + VOL_ONE;
        product  = {{(VOL_W + 1){1'b0}}, shaped} * {{SAMPLE_W{1'b0}}, vol_plus};
        scaled   = SAMPLE_W'(product >> VOL_W);
    end

    // Registered outputs: sample held between conversions, done/overrun are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_reg  <= '0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            done_reg    <= finish;
            overrun_reg <= drop;
            if (finish) begin
                sample_reg <= scaled;
            end
        end
    end

    assign vp.sample  = sample_reg;
    assign vp.done    = done_reg;
    assign vp.overrun = overrun_reg;
    assign vp.busy    = (state_reg != IDLE);

endmodule
